// File: rtl/dadda_mac_8x8.sv
// Flow-controlled multiply-accumulate: registered operands, registered 8x8 product,
// wide accumulator, and one frame result held on a valid/ready output.
module dadda_mac_8x8 #(
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned ACC_W     = 24
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [15:0]      out_count,
    output logic             out_overflow
);

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    // Same arithmetic as the DADDA_8x8_52 partial-product tree, written as
    // shifted partial-product rows so the block stays self-contained.
    function automatic logic [15:0] dadda_8x8_52(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] sum;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + ({8'd0, a & {8{b[i]}}} << i);
        end
        return sum;
    endfunction

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         op_a_q, op_b_q;
    logic               v1_q, v2_q;
    logic [15:0]        prod_q;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;
    logic [15:0]        count_q;
    logic [ACC_W-1:0]   out_sum_q;
    logic [15:0]        out_count_q;
    logic               out_ovf_q;

    logic               accept;
    logic               close;
    logic               drain_done;
    logic               handshake;
    logic [ACC_W:0]     acc_sum;

    assign accept     = in_valid && in_ready_q;
    assign close      = accept && (in_last || (({1'b0, count_q} + 17'd1) == 17'(FRAME_LEN)));
    assign drain_done = (state_q == DRAIN) && !v1_q && !v2_q;
    assign handshake  = out_valid_q && out_ready;
    assign acc_sum    = {1'b0, acc_q} + (ACC_W+1)'(prod_q);

    // NOTE: sequential state uses non-blocking assignments and every register,
    // including the datapath, is cleared by the asynchronous reset so a partial
    // frame can never leak into the next result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ACCUM;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // NOTE: defaulting state_d before the case keeps this block latch-free.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (close)      state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = HOLD;
            HOLD:    if (handshake)  state_d = ACCUM;
            default:                 state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            v1_q        <= 1'b0;
            prod_q      <= '0;
            v2_q        <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                op_a_q <= in_a;
                op_b_q <= in_b;
            end
            v2_q <= v1_q;
            if (v1_q) prod_q <= dadda_8x8_52(op_a_q, op_b_q);

            // The pipeline is empty in HOLD, so clearing never races an update.
            if (handshake) begin
                acc_q   <= '0;
                ovf_q   <= 1'b0;
                count_q <= '0;
            end else begin
                if (v2_q) begin
                    acc_q <= acc_sum[ACC_W-1:0];
                    ovf_q <= ovf_q | acc_sum[ACC_W];
                end
                if (accept) count_q <= count_q + 16'd1;
            end

            if (drain_done) begin
                out_sum_q   <= acc_q;
                out_count_q <= count_q;
                out_ovf_q   <= ovf_q;
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_dadda_mac_8x8.sv
// Bench for dadda_mac_8x8: a 24-bit and a 16-bit accumulator instance share one
// stimulus stream; a frame scoreboard predicts each result for both widths.
module tb_dadda_mac_8x8;

    typedef struct {
        longint sum;
        int     count;
    } frame_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;

    logic        rdy24, vld24, ovf24;
    logic [23:0] sum24;
    logic [15:0] cnt24;
    logic        rdy16, vld16, ovf16;
    logic [15:0] sum16;
    logic [15:0] cnt16;

    int          errors = 0;
    int          checks = 0;

    frame_t      sb_q[$];
    longint      m_sum = 0;
    int          m_count = 0;
    logic        accepted = 1'b0;
    int          n_accepts = 0;
    int          n_results = 0;
    logic [23:0] last_sum24;
    logic [15:0] last_sum16;
    logic [15:0] last_count;
    logic        last_ovf16;

    always #5 clock = ~clock;

    dadda_mac_8x8 #(.FRAME_LEN(16), .ACC_W(24)) u_dut24 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy24),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(vld24),
        .out_ready(out_ready), .out_sum(sum24), .out_count(cnt24), .out_overflow(ovf24)
    );

    dadda_mac_8x8 #(.FRAME_LEN(16), .ACC_W(16)) u_dut16 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy16),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(vld16),
        .out_ready(out_ready), .out_sum(sum16), .out_count(cnt16), .out_overflow(ovf16)
    );

    // One clock: observe at the falling edge (model + scoreboard), then step past
    // the rising edge so new stimulus lands away from it.
    task automatic cycle();
        frame_t exp;
        logic   e_ovf24;
        logic   e_ovf16;
        @(negedge clock);
        accepted = 1'b0;
        if (reset_n && in_valid && rdy24) begin
            accepted = 1'b1;
            n_accepts++;
            m_sum += longint'(in_a) * longint'(in_b);
            m_count++;
            if (in_last || m_count == 16) begin
                sb_q.push_back('{sum: m_sum, count: m_count});
                m_sum   = 0;
                m_count = 0;
            end
        end
        if (reset_n && vld24 && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: result sum=%0d count=%0d but no frame expected", sum24, cnt24);
            end else begin
                exp     = sb_q.pop_front();
                e_ovf24 = (exp.sum >= 64'd16777216);
                e_ovf16 = (exp.sum >= 64'd65536);
                if (sum24 !== 24'(exp.sum) || cnt24 !== 16'(exp.count) || ovf24 !== e_ovf24) begin
                    errors++;
                    $display("FAIL sb_acc24: got sum=%0d count=%0d ovf=%0b, want sum=%0d count=%0d ovf=%0b",
                             sum24, cnt24, ovf24, 24'(exp.sum), exp.count, e_ovf24);
                end
                checks++;
                if (vld16 !== 1'b1 || sum16 !== 16'(exp.sum) || cnt16 !== 16'(exp.count) || ovf16 !== e_ovf16) begin
                    errors++;
                    $display("FAIL sb_acc16: got valid=%0b sum=%0d count=%0d ovf=%0b, want valid=1 sum=%0d count=%0d ovf=%0b",
                             vld16, sum16, cnt16, ovf16, 16'(exp.sum), exp.count, e_ovf16);
                end
                last_sum24 = sum24;
                last_sum16 = sum16;
                last_count = cnt24;
                last_ovf16 = ovf16;
                n_results++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        do begin
            cycle();
            guard++;
        end while (!accepted && guard < 200);
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL send_timeout: pair (%0d,%0d) not accepted within %0d cycles", a, b, guard);
        end
        in_last = 1'b0;
    endtask

    task automatic wait_result();
        int start;
        int guard;
        start = n_results;
        guard = 0;
        while (n_results == start && guard < 100) begin
            cycle();
            guard++;
        end
        checks++;
        if (n_results == start) begin
            errors++;
            $display("FAIL result_timeout: no frame result within %0d cycles", guard);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({rdy24, vld24, sum24, cnt24, ovf24} !== '0 || {rdy16, vld16, sum16, cnt16, ovf16} !== '0) begin
            errors++;
            $display("FAIL reset_values: acc24 rdy=%0b vld=%0b sum=%0d cnt=%0d ovf=%0b acc16 rdy=%0b vld=%0b sum=%0d cnt=%0d ovf=%0b, want all 0",
                     rdy24, vld24, sum24, cnt24, ovf24, rdy16, vld16, sum16, cnt16, ovf16);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (rdy24 !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: in_ready=%0b, want 0", rdy24);
        end
        cycle();
        checks++;
        if (rdy24 !== 1'b1 || rdy16 !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: in_ready=%0b/%0b, want 1/1", rdy24, rdy16);
        end
    endtask

    task automatic test_full_frame();
        for (int i = 1; i <= 16; i++) send(8'(i), 8'd2, 1'b0);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (vld24 !== 1'b0) begin
                errors++;
                $display("FAIL latency_early: out_valid=%0b %0d cycles after close, want 0", vld24, k);
            end
            cycle();
        end
        checks++;
        if (vld24 !== 1'b1 || sum24 !== 24'd272 || cnt24 !== 16'd16 || ovf24 !== 1'b0) begin
            errors++;
            $display("FAIL full_frame: valid=%0b sum=%0d count=%0d ovf=%0b, want 1/272/16/0", vld24, sum24, cnt24, ovf24);
        end
        cycle();
        checks++;
        if (vld24 !== 1'b0 || rdy24 !== 1'b1) begin
            errors++;
            $display("FAIL post_handshake: out_valid=%0b in_ready=%0b, want 0/1", vld24, rdy24);
        end
    endtask

    task automatic test_early_close();
        send(8'd255, 8'd255, 1'b0);
        send(8'd1, 8'd1, 1'b0);
        send(8'd0, 8'd7, 1'b1);
        in_valid = 1'b0;
        wait_result();
        checks++;
        if (last_sum24 !== 24'd65026 || last_count !== 16'd3) begin
            errors++;
            $display("FAIL early_close: sum=%0d count=%0d, want 65026/3", last_sum24, last_count);
        end
    endtask

    task automatic test_overflow();
        send(8'd255, 8'd255, 1'b0);
        send(8'd255, 8'd255, 1'b1);
        in_valid = 1'b0;
        wait_result();
        checks++;
        if (last_sum16 !== 16'd64514 || last_ovf16 !== 1'b1 || last_sum24 !== 24'd130050) begin
            errors++;
            $display("FAIL overflow16: sum16=%0d ovf16=%0b sum24=%0d, want 64514/1/130050",
                     last_sum16, last_ovf16, last_sum24);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] s0;
        logic [15:0] c0;
        logic        o0;
        int          a0;
        int          guard;
        out_ready = 1'b0;
        send(8'd10, 8'd20, 1'b0);
        send(8'd30, 8'd40, 1'b1);
        in_valid = 1'b0;
        guard    = 0;
        while (vld24 !== 1'b1 && guard < 20) begin
            cycle();
            guard++;
        end
        checks++;
        if (vld24 !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid_timeout: out_valid=%0b after %0d cycles, want 1", vld24, guard);
        end
        s0       = sum24;
        c0       = cnt24;
        o0       = ovf24;
        a0       = n_accepts;
        in_valid = 1'b1;
        in_a     = 8'd5;
        in_b     = 8'd6;
        for (int k = 0; k < 10; k++) begin
            cycle();
            checks++;
            if (rdy24 !== 1'b0 || vld24 !== 1'b1 || sum24 !== s0 || cnt24 !== c0 || ovf24 !== o0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d rdy=%0b vld=%0b sum=%0d cnt=%0d ovf=%0b, want 0/1/%0d/%0d/%0b",
                         k, rdy24, vld24, sum24, cnt24, ovf24, s0, c0, o0);
            end
        end
        checks++;
        if (n_accepts != a0 || s0 !== 24'd1400 || c0 !== 16'd2) begin
            errors++;
            $display("FAIL bp_result: accepts during hold=%0d sum=%0d count=%0d, want 0/1400/2", n_accepts - a0, s0, c0);
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (rdy24 !== 1'b1 || vld24 !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%0b out_valid=%0b, want 1/0", rdy24, vld24);
        end
        for (int i = 0; i < 16; i++) send(8'd5, 8'd6, 1'b0);
        in_valid = 1'b0;
        wait_result();
        checks++;
        if (last_sum24 !== 24'd480 || last_count !== 16'd16) begin
            errors++;
            $display("FAIL bp_next_frame: sum=%0d count=%0d, want 480/16", last_sum24, last_count);
        end
    endtask

    task automatic test_gapped();
        int start;
        start = n_results;
        for (int i = 1; i <= 100; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) cycle();
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), (i == 100));
        end
        in_valid = 1'b0;
        wait_result();
        repeat (8) cycle();
        checks++;
        if (n_results - start != 7 || last_count !== 16'd4) begin
            errors++;
            $display("FAIL gapped_frames: results=%0d last_count=%0d, want 7/4", n_results - start, last_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 5; i++) send(8'd9, 8'd9, 1'b0);
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        m_sum   = 0;
        m_count = 0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({rdy24, vld24, sum24, cnt24, ovf24} !== '0 || {rdy16, vld16, sum16, cnt16, ovf16} !== '0) begin
                errors++;
                $display("FAIL mid_reset_outputs: rdy=%0b vld=%0b sum=%0d cnt=%0d ovf=%0b, want all 0",
                         rdy24, vld24, sum24, cnt24, ovf24);
            end
            cycle();
        end
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) send(8'd3, 8'd3, 1'b0);
        in_valid = 1'b0;
        wait_result();
        checks++;
        if (last_sum24 !== 24'd144 || last_count !== 16'd16) begin
            errors++;
            $display("FAIL post_reset_frame: sum=%0d count=%0d, want 144/16", last_sum24, last_count);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_early_close();
        test_overflow();
        test_backpressure();
        test_gapped();
        test_reset_mid_frame();
        repeat (6) cycle();
        checks++;
        if (sb_q.size() != 0 || m_count != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d frames never produced, %0d products pending", sb_q.size(), m_count);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
